// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer.
// Holds the default index width, the data/register widths, the entry type
// codes and the packed layout of one buffer entry.
package reorder_buffer_pkg;

    localparam int unsigned ROB_BIT_DEFAULT = 4;
    localparam int unsigned XLEN            = 32;
    localparam int unsigned REG_BIT         = 5;

    typedef enum logic [1:0] {
        ENT_REG    = 2'd0,
        ENT_STORE  = 2'd1,
        ENT_BRANCH = 2'd2,
        ENT_EXIT   = 2'd3
    } entry_type_t;

    typedef struct packed {
        logic                busy;
        logic                ready;
        entry_type_t         kind;
        logic [REG_BIT-1:0]  rd;
        logic [XLEN-1:0]     alt_pc;
        logic                pred_taken;
        logic                taken;
        logic [XLEN-1:0]     value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue of in-flight instructions that retires them
// in program order, one per cycle, and flushes on a branch mispredict.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global stall: low holds state)
//   issue_*          : allocate an entry at tail_entry (ignored while full)
//   cdb_*            : result writeback into a busy entry
//   get_rob_entry1/2 : combinational operand lookup -> ready1/2, value1/2
//   commit_*         : registered single-cycle register/store retire pulses
//   rob_clear_up / clear_pc : mispredict flush pulse and redirect PC
//   halt             : sticky, set when an EXIT entry retires
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_BIT = ROB_BIT_DEFAULT
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,

    input  logic                issue_valid,
    input  logic [1:0]          issue_type,
    input  logic [REG_BIT-1:0]  issue_rd,
    input  logic [XLEN-1:0]     issue_pc,
    input  logic [XLEN-1:0]     issue_alt_pc,
    input  logic                issue_pred_taken,
    input  logic                issue_ready,
    input  logic [XLEN-1:0]     issue_value,
    output logic [ROB_BIT-1:0]  tail_entry,
    output logic                full,

    input  logic                cdb_valid,
    input  logic [ROB_BIT-1:0]  cdb_entry,
    input  logic [XLEN-1:0]     cdb_value,
    input  logic                cdb_taken,

    input  logic [ROB_BIT-1:0]  get_rob_entry1,
    input  logic [ROB_BIT-1:0]  get_rob_entry2,
    output logic                ready1,
    output logic                ready2,
    output logic [XLEN-1:0]     value1,
    output logic [XLEN-1:0]     value2,

    output logic [REG_BIT-1:0]  commit_reg_id,
    output logic [XLEN-1:0]     commit_reg_data,
    output logic [ROB_BIT-1:0]  commit_rob_entry,
    output logic                commit_store,
    output logic [ROB_BIT-1:0]  commit_store_entry,
    output logic                rob_clear_up,
    output logic [XLEN-1:0]     clear_pc,
    output logic                halt
);

    localparam int unsigned        ROB_SIZE = 1 << ROB_BIT;
    localparam logic [ROB_BIT-1:0] IDX_ONE  = {{(ROB_BIT-1){1'b0}}, 1'b1};
    localparam logic [ROB_BIT:0]   CNT_FULL = {1'b1, {ROB_BIT{1'b0}}};

    rob_entry_t         rob [ROB_SIZE];
    logic [ROB_BIT-1:0] head;
    logic [ROB_BIT-1:0] tail;
    logic [ROB_BIT:0]   count;

    rob_entry_t         head_e;
    logic               do_issue;
    logic               do_commit;
    logic               mispredict;
    logic               reg_write;

    // The instruction PC is not needed to retire; only alt_pc drives redirect.
    logic unused_pc;
    assign unused_pc = ^issue_pc;

    assign tail_entry = tail;
    assign full       = (count == CNT_FULL);
    assign head_e     = rob[head];

    // The flush cycle swallows issue, CDB and commit.
    assign do_issue   = rdy_in && !rob_clear_up && issue_valid && !full;
    assign do_commit  = rdy_in && !rob_clear_up && (count != '0)
                        && head_e.busy && head_e.ready;
    assign mispredict = (head_e.kind == ENT_BRANCH) && (head_e.taken != head_e.pred_taken);
    assign reg_write  = ((head_e.kind == ENT_REG) || (head_e.kind == ENT_BRANCH))
                        && (head_e.rd != '0);

    // Two identical lookup ports; a same-cycle CDB write is forwarded.
    logic [ROB_BIT-1:0] lk_idx   [2];
    logic               lk_ready [2];
    logic [XLEN-1:0]    lk_value [2];

    assign lk_idx[0] = get_rob_entry1;
    assign lk_idx[1] = get_rob_entry2;

    for (genvar g = 0; g < 2; g++) begin : g_lookup
        logic hit;
        assign hit         = cdb_valid && (cdb_entry == lk_idx[g]);
        assign lk_ready[g] = rob[lk_idx[g]].ready || hit;
        assign lk_value[g] = hit ? cdb_value : rob[lk_idx[g]].value;
    end

    assign ready1 = lk_ready[0];
    assign ready2 = lk_ready[1];
    assign value1 = lk_value[0];
    assign value2 = lk_value[1];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            commit_reg_id      <= '0;
            commit_reg_data    <= '0;
            commit_rob_entry   <= '0;
            commit_store       <= 1'b0;
            commit_store_entry <= '0;
            rob_clear_up       <= 1'b0;
            clear_pc           <= '0;
            halt               <= 1'b0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                rob[i] <= '0;
            end
        end else if (rdy_in) begin
            commit_reg_id      <= '0;
            commit_reg_data    <= '0;
            commit_rob_entry   <= '0;
            commit_store       <= 1'b0;
            commit_store_entry <= '0;
            rob_clear_up       <= 1'b0;
            clear_pc           <= '0;

            if (rob_clear_up) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                    rob[i].busy  <= 1'b0;
                    rob[i].ready <= 1'b0;
                end
            end else begin
                if (do_issue) begin
                    rob[tail] <= '{busy:       1'b1,
                                   ready:      issue_ready,
                                   kind:       entry_type_t'(issue_type),
                                   rd:         issue_rd,
                                   alt_pc:     issue_alt_pc,
                                   pred_taken: issue_pred_taken,
                                   taken:      1'b0,
                                   value:      issue_value};
                    tail <= tail + IDX_ONE;
                end

                if (cdb_valid && rob[cdb_entry].busy) begin
                    rob[cdb_entry].value <= cdb_value;
                    rob[cdb_entry].ready <= 1'b1;
                    rob[cdb_entry].taken <= cdb_taken;
                end

                // Placed after the CDB write so freeing the head wins.
                if (do_commit) begin
                    rob[head].busy  <= 1'b0;
                    rob[head].ready <= 1'b0;
                    head            <= head + IDX_ONE;
                    if (reg_write) begin
                        commit_reg_id    <= head_e.rd;
                        commit_reg_data  <= head_e.value;
                        commit_rob_entry <= head;
                    end
                    if (head_e.kind == ENT_STORE) begin
                        commit_store       <= 1'b1;
                        commit_store_entry <= head;
                    end
                    if (head_e.kind == ENT_EXIT) begin
                        halt <= 1'b1;
                    end
                    if (mispredict) begin
                        rob_clear_up <= 1'b1;
                        clear_pc     <= head_e.alt_pc;
                    end
                end

                count <= count + {{ROB_BIT{1'b0}}, do_issue} - {{ROB_BIT{1'b0}}, do_commit};
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic [31:0] issue_alt_pc;
    logic        issue_pred_taken;
    logic        issue_ready;
    logic [31:0] issue_value;
    logic [3:0]  tail_entry;
    logic        full;
    logic        cdb_valid;
    logic [3:0]  cdb_entry;
    logic [31:0] cdb_value;
    logic        cdb_taken;
    logic [3:0]  get_rob_entry1;
    logic [3:0]  get_rob_entry2;
    logic        ready1;
    logic        ready2;
    logic [31:0] value1;
    logic [31:0] value2;
    logic [4:0]  commit_reg_id;
    logic [31:0] commit_reg_data;
    logic [3:0]  commit_rob_entry;
    logic        commit_store;
    logic [3:0]  commit_store_entry;
    logic        rob_clear_up;
    logic [31:0] clear_pc;
    logic        halt;

    localparam logic [1:0] T_REG = 2'd0, T_STORE = 2'd1, T_BRANCH = 2'd2, T_EXIT = 2'd3;
    localparam int K_REG = 0, K_STORE = 1, K_FLUSH = 2;

    reorder_buffer #(.ROB_BIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_alt_pc(issue_alt_pc),
        .issue_pred_taken(issue_pred_taken), .issue_ready(issue_ready),
        .issue_value(issue_value), .tail_entry(tail_entry), .full(full),
        .cdb_valid(cdb_valid), .cdb_entry(cdb_entry), .cdb_value(cdb_value),
        .cdb_taken(cdb_taken), .get_rob_entry1(get_rob_entry1),
        .get_rob_entry2(get_rob_entry2), .ready1(ready1), .ready2(ready2),
        .value1(value1), .value2(value2), .commit_reg_id(commit_reg_id),
        .commit_reg_data(commit_reg_data), .commit_rob_entry(commit_rob_entry),
        .commit_store(commit_store), .commit_store_entry(commit_store_entry),
        .rob_clear_up(rob_clear_up), .clear_pc(clear_pc), .halt(halt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          kind;
        logic [4:0]  id;
        logic [31:0] data;
        logic [3:0]  entry;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic last_rdy = 1'b0;
    logic last_rst = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic void push_exp(input int k, input logic [4:0] id,
                                     input logic [31:0] d, input logic [3:0] e);
        exp_t x;
        x.kind = k; x.id = id; x.data = d; x.entry = e;
        sb.push_back(x);
    endfunction

    // Outputs only change on an edge where rdy_in was high and reset was low.
    always @(posedge clk_in) begin
        last_rdy <= rdy_in;
        last_rst <= rst_in;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (last_rdy && !last_rst) begin
                if (commit_reg_id != 5'd0) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_reg_commit: got id=%0d data=0x%0h expected none",
                                 commit_reg_id, commit_reg_data);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_kind_reg", K_REG, e.kind);
                        chk("sb_reg_id", {27'd0, commit_reg_id}, {27'd0, e.id});
                        chk("sb_reg_data", commit_reg_data, e.data);
                        chk("sb_reg_entry", {28'd0, commit_rob_entry}, {28'd0, e.entry});
                    end
                end
                if (commit_store) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_store_commit: got entry=%0d expected none",
                                 commit_store_entry);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_kind_store", K_STORE, e.kind);
                        chk("sb_store_entry", {28'd0, commit_store_entry}, {28'd0, e.entry});
                    end
                end
                if (rob_clear_up) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_flush: got clear_pc=0x%0h expected none", clear_pc);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_kind_flush", K_FLUSH, e.kind);
                        chk("sb_clear_pc", clear_pc, e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue_op(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] alt,
                            input logic pred, input logic rdy, input logic [31:0] val);
        issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_alt_pc = alt;
        issue_pred_taken = pred; issue_ready = rdy; issue_value = val;
        issue_pc = 32'h1000 + {27'd0, rd};
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] ent, input logic [31:0] val, input logic tk);
        cdb_valid = 1'b1; cdb_entry = ent; cdb_value = val; cdb_taken = tk;
        tick();
        cdb_valid = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b0;
        issue_valid = 1'b0; issue_type = T_REG; issue_rd = '0; issue_pc = '0;
        issue_alt_pc = '0; issue_pred_taken = 1'b0; issue_ready = 1'b0; issue_value = '0;
        cdb_valid = 1'b0; cdb_entry = '0; cdb_value = '0; cdb_taken = 1'b0;
        get_rob_entry1 = '0; get_rob_entry2 = '0;

        // Reset with rdy_in low still takes effect.
        ticks(2);
        chk("rst_tail", {28'd0, tail_entry}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_clear", {31'd0, rob_clear_up}, 32'd0);
        chk("rst_reg_id", {27'd0, commit_reg_id}, 32'd0);
        chk("rst_store", {31'd0, commit_store}, 32'd0);
        rst_in = 1'b0; rdy_in = 1'b1;

        // Ready-at-issue REG: commit pulse one edge after the issue edge.
        push_exp(K_REG, 5'd5, 32'h1234, 4'd0);
        issue_op(T_REG, 5'd5, 32'd0, 1'b0, 1'b1, 32'h1234);
        chk("lat_pre", {27'd0, commit_reg_id}, 32'd0);
        tick();
        chk("lat_reg_id", {27'd0, commit_reg_id}, 32'd5);
        chk("lat_reg_data", commit_reg_data, 32'h1234);
        chk("lat_entry", {28'd0, commit_rob_entry}, 32'd0);
        tick();
        chk("lat_pulse_end", {27'd0, commit_reg_id}, 32'd0);

        // Entries 1..3 not ready; CDB bypass on lookup; out-of-order CDB.
        issue_op(T_REG, 5'd1, 32'd0, 1'b0, 1'b0, 32'd0);
        issue_op(T_REG, 5'd2, 32'd0, 1'b0, 1'b0, 32'd0);
        issue_op(T_REG, 5'd3, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("tail_after3", {28'd0, tail_entry}, 32'd4);
        push_exp(K_REG, 5'd1, 32'h11, 4'd1);
        push_exp(K_REG, 5'd2, 32'h22, 4'd2);
        push_exp(K_REG, 5'd3, 32'hAB, 4'd3);
        cdb_valid = 1'b1; cdb_entry = 4'd3; cdb_value = 32'hAB; cdb_taken = 1'b0;
        get_rob_entry1 = 4'd3; get_rob_entry2 = 4'd2;
        #1;
        chk("bypass_ready1", {31'd0, ready1}, 32'd1);
        chk("bypass_value1", value1, 32'hAB);
        chk("bypass_ready2", {31'd0, ready2}, 32'd0);
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("stored_ready1", {31'd0, ready1}, 32'd1);
        chk("stored_value1", value1, 32'hAB);
        ticks(2);
        chk("no_commit_yet", {27'd0, commit_reg_id}, 32'd0);
        cdb(4'd2, 32'h22, 1'b0);
        ticks(2);
        cdb(4'd1, 32'h11, 1'b0);
        ticks(4);

        // CDB to a free entry leaves it not ready.
        cdb(4'd9, 32'h99, 1'b0);
        get_rob_entry2 = 4'd9;
        #1;
        chk("cdb_free_ignored", {31'd0, ready2}, 32'd0);

        // Store retire, and REG with rd=0 retires silently.
        push_exp(K_STORE, 5'd0, 32'd0, 4'd4);
        issue_op(T_STORE, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0);
        issue_op(T_REG, 5'd0, 32'd0, 1'b0, 1'b1, 32'h55);
        ticks(3);
        chk("tail_after_store", {28'd0, tail_entry}, 32'd6);

        // Fill from a fresh reset; the cycle right after reset accepts issue.
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            issue_op(T_REG, 5'(i + 1), 32'd0, 1'b0, 1'b0, 32'd0);
        end
        chk("full_set", {31'd0, full}, 32'd1);
        chk("full_tail_wrap", {28'd0, tail_entry}, 32'd0);
        issue_op(T_REG, 5'd20, 32'd0, 1'b0, 1'b1, 32'hDEAD);
        chk("full_17th_tail", {28'd0, tail_entry}, 32'd0);
        chk("full_17th_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            push_exp(K_REG, 5'(i + 1), 32'h1000 + i, 4'(i));
        end
        for (int i = 0; i < 16; i++) begin
            cdb(4'(i), 32'h1000 + i, 1'b0);
        end
        ticks(3);
        chk("drained_full", {31'd0, full}, 32'd0);
        chk("drained_tail", {28'd0, tail_entry}, 32'd0);

        // Stall with a ready head: nothing retires until rdy_in returns.
        issue_op(T_REG, 5'd9, 32'd0, 1'b0, 1'b0, 32'd0);
        cdb_valid = 1'b1; cdb_entry = 4'd0; cdb_value = 32'h900; cdb_taken = 1'b0;
        tick();
        cdb_valid = 1'b0; rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_no_commit", {27'd0, commit_reg_id}, 32'd0);
        end
        push_exp(K_REG, 5'd9, 32'h900, 4'd0);
        rdy_in = 1'b1;
        tick();
        chk("resume_reg_id", {27'd0, commit_reg_id}, 32'd9);
        tick();

        // Correctly predicted branch retires without a flush.
        issue_op(T_BRANCH, 5'd0, 32'h200, 1'b1, 1'b0, 32'd0);
        cdb(4'd1, 32'd0, 1'b1);
        ticks(2);

        // Mispredicted branch at entry 2 with three younger entries.
        issue_op(T_BRANCH, 5'd0, 32'h100, 1'b0, 1'b0, 32'd0);
        issue_op(T_REG, 5'd10, 32'd0, 1'b0, 1'b0, 32'd0);
        issue_op(T_REG, 5'd11, 32'd0, 1'b0, 1'b0, 32'd0);
        issue_op(T_REG, 5'd12, 32'd0, 1'b0, 1'b0, 32'd0);
        push_exp(K_FLUSH, 5'd0, 32'h100, 4'd0);
        cdb(4'd2, 32'd0, 1'b1);
        tick();
        chk("flush_pulse", {31'd0, rob_clear_up}, 32'd1);
        chk("flush_pc", clear_pc, 32'h100);
        // Both of these must be dropped during the flush cycle.
        issue_valid = 1'b1; issue_type = T_REG; issue_rd = 5'd15;
        issue_ready = 1'b1; issue_value = 32'hBAD;
        cdb_valid = 1'b1; cdb_entry = 4'd3; cdb_value = 32'h77;
        tick();
        issue_valid = 1'b0; cdb_valid = 1'b0;
        chk("flush_pulse_end", {31'd0, rob_clear_up}, 32'd0);
        chk("flush_tail", {28'd0, tail_entry}, 32'd0);
        chk("flush_full", {31'd0, full}, 32'd0);
        get_rob_entry1 = 4'd3;
        #1;
        chk("flush_entry_cleared", {31'd0, ready1}, 32'd0);
        ticks(3);
        push_exp(K_REG, 5'd3, 32'h333, 4'd0);
        issue_op(T_REG, 5'd3, 32'd0, 1'b0, 1'b1, 32'h333);
        ticks(2);

        // EXIT sets a sticky halt that only reset clears.
        issue_op(T_EXIT, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0);
        tick();
        chk("halt_set", {31'd0, halt}, 32'd1);
        ticks(2);
        chk("halt_sticky", {31'd0, halt}, 32'd1);
        rst_in = 1'b1;
        tick();
        chk("halt_reset", {31'd0, halt}, 32'd0);
        chk("rst2_tail", {28'd0, tail_entry}, 32'd0);
        rst_in = 1'b0;
        ticks(2);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
